// File: rtl/instruction_fetch.sv
// Fetch stage: PC, word-addressed instruction memory and the execute-phase counter `loop` for the decoder.
// Latency: instruction valid 1 cycle after FETCH; each unstalled instruction occupies 1+PHASES cycles.
// Backpressure: `stall` freezes FETCH/EXEC progress; memory writes are accepted regardless of state.
// Ports: clk/reset (sync, active-high); stall; branch_taken/branch_target (sampled on the advancing cycle);
//        imem_we/imem_waddr/imem_wdata (write port); instruction/pc/loop/valid/halted/retired (decoder view).
module instruction_fetch #(
    parameter int          IMEM_DEPTH = 64,
    parameter int          PHASES     = 5,
    parameter logic [31:0] RESET_PC   = 32'h0
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          stall,
    input  logic                          branch_taken,
    input  logic [31:0]                   branch_target,
    input  logic                          imem_we,
    input  logic [$clog2(IMEM_DEPTH)-1:0] imem_waddr,
    input  logic [31:0]                   imem_wdata,
    output logic [31:0]                   instruction,
    output logic [31:0]                   pc,
    output logic [2:0]                    loop,
    output logic                          valid,
    output logic                          halted,
    output logic [31:0]                   retired
);

    localparam int          AW         = $clog2(IMEM_DEPTH);
    // One extra bit so the byte-address limit never overflows for large depths.
    localparam logic [32:0] PC_LIMIT   = 33'(IMEM_DEPTH) << 2;
    localparam logic [2:0]  LAST_PHASE = 3'(PHASES - 1);
    localparam logic [31:0] NOP        = 32'h0000_0013;

    typedef enum logic [1:0] {S_FETCH, S_EXEC, S_HALT} state_t;

    state_t      state;
    state_t      state_nxt;
    logic [31:0] imem [IMEM_DEPTH];
    logic [31:0] fetch_word;
    logic        pc_out_of_range;
    logic        fetch_halt;
    logic        last_phase;
    logic [31:0] pc_q;
    logic [31:0] instr_q;
    logic [31:0] retired_q;
    logic [2:0]  loop_q;

    // Write port: a write landing on the same edge as a FETCH of that word
    // is not visible to the fetch, which reads the array before the update.
    always_ff @(posedge clk) begin
        if (imem_we) begin
            imem[imem_waddr] <= imem_wdata;
        end
    end

    assign pc_out_of_range = ({1'b0, pc_q} >= PC_LIMIT);
    assign fetch_word      = imem[pc_q[AW+1:2]];
    // A zero word is the end-of-program sentinel.
    assign fetch_halt      = pc_out_of_range || (fetch_word == 32'h0);
    assign last_phase      = (loop_q == LAST_PHASE);

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_FETCH;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        unique case (state)
            S_FETCH: if (!stall) state_nxt = fetch_halt ? S_HALT : S_EXEC;
            S_EXEC:  if (!stall && last_phase) state_nxt = S_FETCH;
            S_HALT:  state_nxt = S_HALT;
            default: state_nxt = S_HALT;
        endcase
    end

    // Datapath registers: PC, latched instruction, phase counter, retire count.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q      <= RESET_PC;
            loop_q    <= 3'd0;
            instr_q   <= NOP;
            retired_q <= 32'd0;
        end else begin
            unique case (state)
                S_FETCH: begin
                    if (!stall) begin
                        // On halt the PC stays at the offending address.
                        instr_q <= fetch_halt ? NOP : fetch_word;
                        loop_q  <= 3'd0;
                    end
                end
                S_EXEC: begin
                    if (!stall) begin
                        if (last_phase) begin
                            // Branch inputs only matter on this advancing cycle.
                            pc_q      <= branch_taken ? (branch_target & ~32'h3) : pc_q + 32'd4;
                            retired_q <= retired_q + 32'd1;
                        end else begin
                            loop_q <= loop_q + 3'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Outputs
    always_comb begin
        instruction = instr_q;
        pc          = pc_q;
        loop        = loop_q;
        retired     = retired_q;
        valid       = (state == S_EXEC);
        halted      = (state == S_HALT);
    end

endmodule

// File: tb/tb_instruction_fetch.sv
module tb_instruction_fetch;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Main DUT (64 words)
    logic        reset, stall, branch_taken, imem_we;
    logic [31:0] branch_target, imem_wdata;
    logic [5:0]  imem_waddr;
    logic [31:0] instruction, pc, retired;
    logic [2:0]  loop;
    logic        valid, halted;

    // Small DUT (4 words, no sentinel)
    logic        s_reset, s_stall, s_branch_taken, s_imem_we;
    logic [31:0] s_branch_target, s_imem_wdata;
    logic [1:0]  s_imem_waddr;
    logic [31:0] s_instruction, s_pc, s_retired;
    logic [2:0]  s_loop;
    logic        s_valid, s_halted;

    instruction_fetch #(.IMEM_DEPTH(64), .PHASES(5), .RESET_PC(32'h0)) dut (
        .clk(clk), .reset(reset), .stall(stall), .branch_taken(branch_taken),
        .branch_target(branch_target), .imem_we(imem_we), .imem_waddr(imem_waddr),
        .imem_wdata(imem_wdata), .instruction(instruction), .pc(pc), .loop(loop),
        .valid(valid), .halted(halted), .retired(retired)
    );

    instruction_fetch #(.IMEM_DEPTH(4), .PHASES(5), .RESET_PC(32'h0)) dut_small (
        .clk(clk), .reset(s_reset), .stall(s_stall), .branch_taken(s_branch_taken),
        .branch_target(s_branch_target), .imem_we(s_imem_we), .imem_waddr(s_imem_waddr),
        .imem_wdata(s_imem_wdata), .instruction(s_instruction), .pc(s_pc), .loop(s_loop),
        .valid(s_valid), .halted(s_halted), .retired(s_retired)
    );

    int tests = 0;
    int fails = 0;
    logic [31:0] prog [5];

    typedef struct {
        string           name;
        int              stall_pc;      // -1: no stall
        logic [2:0]      stall_loop;
        int              stall_len;
        int              br_pc;         // -1: no branch
        logic [31:0]     br_target;
        bit              br_with_stall;
        int              n_exp;
        logic [3:0][31:0] exp_pc;
        logic [31:0]     exp_retired;
        logic [31:0]     exp_halt_pc;
        int              exp_halt_cycle;
    } vec_t;

    vec_t vecs [4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Leaves reset asserted, sampled #1 after an edge.
    task automatic do_reset();
        reset = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = 32'h0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic run_vec(input vec_t v);
        logic [31:0] q [$];
        logic [31:0] e;
        int cyc, stall_left, br_stage;
        bit prev_valid, stall_used, done;
        do_reset();
        check({v.name, "_rst_pc"}, pc, 32'h0);
        check({v.name, "_rst_halted"}, {31'b0, halted}, 32'h0);
        check({v.name, "_rst_retired"}, retired, 32'h0);
        for (int i = 0; i < v.n_exp; i++) q.push_back(v.exp_pc[i]);
        reset = 1'b0;
        cyc = 0; stall_left = 0; br_stage = 0;
        prev_valid = 1'b0; stall_used = 1'b0; done = 1'b0;
        while (!done && cyc < 300) begin
            @(posedge clk); #1;
            cyc++;
            if (valid && !prev_valid) begin
                if (q.size() == 0) begin
                    check({v.name, "_extra_instr"}, pc, 32'hFFFF_FFFF);
                end else begin
                    e = q.pop_front();
                    check({v.name, "_pc"}, pc, e);
                    check({v.name, "_instr"}, instruction, prog[e[4:2]]);
                    check({v.name, "_loop0"}, {29'b0, loop}, 32'h0);
                end
            end
            prev_valid = valid;
            if (stall_left > 0) begin
                check({v.name, "_stall_hold"}, {29'b0, loop}, {29'b0, v.stall_loop});
                stall_left--;
                if (stall_left == 0) stall = 1'b0;
            end else if (!stall_used && valid && int'(pc) == v.stall_pc && loop == v.stall_loop) begin
                stall = 1'b1; stall_left = v.stall_len; stall_used = 1'b1;
            end
            if (br_stage == 1) begin
                stall = 1'b0; branch_taken = 1'b0; br_stage = 2;
            end else if (br_stage == 0 && valid && int'(pc) == v.br_pc && loop == 3'd4) begin
                branch_taken = 1'b1; branch_target = v.br_target;
                if (v.br_with_stall) stall = 1'b1;
                br_stage = 1;
            end
            if (halted) begin
                done = 1'b1;
                check({v.name, "_halt_pc"}, pc, v.exp_halt_pc);
                check({v.name, "_halt_valid"}, {31'b0, valid}, 32'h0);
                check({v.name, "_halt_instr"}, instruction, NOP);
                check({v.name, "_halt_loop"}, {29'b0, loop}, 32'h0);
                check({v.name, "_retired"}, retired, v.exp_retired);
                check({v.name, "_halt_cycle"}, cyc, v.exp_halt_cycle);
                check({v.name, "_missing_instr"}, q.size(), 32'h0);
            end
        end
        if (!done) check({v.name, "_timeout"}, 32'h0, 32'h1);
    endtask

    initial begin
        int cyc;
        bit found;
        logic [31:0] ret_before;

        prog[0] = 32'h0010_0093;  // addi x1,x0,1
        prog[1] = 32'h0020_0113;  // addi x2,x0,2
        prog[2] = 32'h0000_3183;  // ld   x3,0(x0)
        prog[3] = 32'h0030_3423;  // sd   x3,8(x0)
        prog[4] = 32'h0000_0000;  // sentinel

        vecs[0] = '{"seq",      -1, 3'd0, 0, -1, 32'h0,  1'b0, 4,
                    {32'd12, 32'd8, 32'd4, 32'd0}, 32'd4, 32'd16, 25};
        vecs[1] = '{"stall",     4, 3'd2, 3, -1, 32'h0,  1'b0, 4,
                    {32'd12, 32'd8, 32'd4, 32'd0}, 32'd4, 32'd16, 28};
        vecs[2] = '{"branch",   -1, 3'd0, 0,  0, 32'hE,  1'b0, 2,
                    {32'd0,  32'd0, 32'd12, 32'd0}, 32'd2, 32'd16, 13};
        vecs[3] = '{"stall_br", -1, 3'd0, 0,  0, 32'hE,  1'b1, 4,
                    {32'd12, 32'd8, 32'd4, 32'd0}, 32'd4, 32'd16, 26};

        reset = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = 32'h0;
        s_reset = 1'b1; s_stall = 1'b0; s_branch_taken = 1'b0; s_branch_target = 32'h0;
        imem_we = 1'b0; imem_waddr = '0; imem_wdata = '0;
        s_imem_we = 1'b0; s_imem_waddr = '0; s_imem_wdata = '0;

        // Load both programs while held in reset.
        for (int i = 0; i < 5; i++) begin
            imem_we = 1'b1; imem_waddr = 6'(i); imem_wdata = prog[i];
            s_imem_we = (i < 4); s_imem_waddr = 2'(i); s_imem_wdata = prog[i];
            @(posedge clk); #1;
        end
        imem_we = 1'b0; s_imem_we = 1'b0;

        check("reset_pc", pc, 32'h0);
        check("reset_loop", {29'b0, loop}, 32'h0);
        check("reset_instr", instruction, NOP);
        check("reset_valid", {31'b0, valid}, 32'h0);
        check("reset_halted", {31'b0, halted}, 32'h0);
        check("reset_retired", retired, 32'h0);

        for (int t = 0; t < 4; t++) run_vec(vecs[t]);

        // No sentinel, 4-word memory: PC runs off the end.
        s_reset = 1'b0;
        cyc = 0; found = 1'b0;
        while (!found && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
            if (s_halted) found = 1'b1;
        end
        check("oor_halted", {31'b0, found}, 32'h1);
        check("oor_cycle", cyc, 32'd25);
        check("oor_pc", s_pc, 32'd16);
        check("oor_valid", {31'b0, s_valid}, 32'h0);
        check("oor_instr", s_instruction, NOP);
        check("oor_retired", s_retired, 32'd4);

        // Reset mid-EXEC at loop 3 of word 2.
        do_reset();
        reset = 1'b0;
        cyc = 0; found = 1'b0;
        while (!found && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
            if (valid && pc == 32'd8 && loop == 3'd3) found = 1'b1;
        end
        check("midrst_reached", {31'b0, found}, 32'h1);
        ret_before = retired;
        check("midrst_retired_before", ret_before, 32'd2);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("midrst_pc", pc, 32'h0);
        check("midrst_loop", {29'b0, loop}, 32'h0);
        check("midrst_valid", {31'b0, valid}, 32'h0);
        check("midrst_retired", retired, 32'h0);
        @(posedge clk); #1;
        check("midrst_refetch_valid", {31'b0, valid}, 32'h1);
        check("midrst_refetch_pc", pc, 32'h0);
        check("midrst_refetch_instr", instruction, prog[0]);

        // Write to word 0 on the same edge that fetches it: old word is returned.
        do_reset();
        reset = 1'b0;
        imem_we = 1'b1; imem_waddr = 6'd0; imem_wdata = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        imem_we = 1'b0;
        check("wr_fetch_old", instruction, prog[0]);
        check("wr_fetch_valid", {31'b0, valid}, 32'h1);
        do_reset();
        reset = 1'b0;
        @(posedge clk); #1;
        check("wr_fetch_new", instruction, 32'hDEAD_BEEF);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
